// File: rtl/usi_dma_pkg.sv
// Shared types and sizing helpers for the USI <-> DMAC handshake bridge.
package usi_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } hs_state_e;

    localparam int TIMEOUT_CYC_DEF = 1024;

    // Width needed to hold 0..cyc; never below one bit so a disabled (0) setting still elaborates.
    function automatic int timer_w(input int cyc);
        return (cyc < 1) ? 1 : $clog2(cyc + 1);
    endfunction

    localparam int TIMER_W = timer_w(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/usi_dma_hs_chan.sv
// One direction of the bridge: request FSM, shared REQ/HOLD timer, burst counter and sticky flags.
module usi_dma_hs_chan
    import usi_dma_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int GAP_CYC     = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             trust_i,
    input  logic             usi_req_i,
    input  logic             dmac_ack_i,
    input  logic             dmac_sec_i,
    output logic             usi_ack_o,
    output logic             dmac_req_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_to_o,
    output logic             sec_viol_o
);

    // The same counter times the REQ watchdog and the HOLD gap, so it is sized for the larger of the two.
    localparam int TO_W    = timer_w(TIMEOUT_CYC);
    localparam int GAP_EFF = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam int GAP_W   = timer_w(GAP_EFF);
    localparam int CYC_W   = (TO_W > GAP_W) ? TO_W : GAP_W;
    localparam bit TO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [CYC_W-1:0] TO_LAST  = CYC_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CYC_W-1:0] GAP_LAST = CYC_W'(GAP_EFF - 1);

    hs_state_e        state_q, state_d;
    logic [CYC_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             usiAck_q, errTo_q, secViol_q;
    logic             allowed, startEvt, violEvt, ackEvt, toEvt, gapDone;

    // State register; reset returns to IDLE so dmac_req drops the cycle after rst.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: a started burst always ends by ack or timeout, independent of en/usi_req.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startEvt) state_d = REQ;
            REQ:     if (ackEvt) state_d = HOLD;
                     else if (toEvt) state_d = IDLE;
            HOLD:    if (gapDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and event decode; trust and channel security only matter when leaving IDLE.
    always_comb begin
        allowed    = !trust_i || dmac_sec_i;
        startEvt   = (state_q == IDLE) && en_i && usi_req_i && allowed;
        violEvt    = (state_q == IDLE) && en_i && usi_req_i && !allowed;
        ackEvt     = (state_q == REQ) && dmac_ack_i;
        toEvt      = TO_EN && (state_q == REQ) && !dmac_ack_i && (timer_q == TO_LAST);
        gapDone    = (state_q == HOLD) && (timer_q == GAP_LAST);
        dmac_req_o = (state_q == REQ);
    end

    // Datapath next values: timer restarts on every state change; a set beats clr, an increment after clr gives 1.
    always_comb begin
        timer_d = timer_q + 1'b1;
        if (state_q == IDLE || state_d != state_q) timer_d = '0;
        cnt_d = cnt_q;
        if (ackEvt)     cnt_d = clr_i ? CNT_W'(1) : cnt_q + 1'b1;
        else if (clr_i) cnt_d = '0;
    end

    // Datapath registers: timer, counter, ack pulse and sticky flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q   <= '0;
            cnt_q     <= '0;
            usiAck_q  <= 1'b0;
            errTo_q   <= 1'b0;
            secViol_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            usiAck_q  <= ackEvt;
            errTo_q   <= toEvt || (errTo_q && !clr_i);
            secViol_q <= violEvt || (secViol_q && !clr_i);
        end
    end

    assign usi_ack_o  = usiAck_q;
    assign cnt_o      = cnt_q;
    assign err_to_o   = errTo_q;
    assign sec_viol_o = secViol_q;

endmodule

// File: rtl/usi_dma_hs_bridge.sv
// Bridge top: two independent handshake channels plus the registered interrupt.
module usi_dma_hs_bridge
    import usi_dma_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int GAP_CYC     = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             tipc_trust_i,
    input  logic             usi_req_tx_i,
    input  logic             usi_req_rx_i,
    output logic             usi_ack_tx_o,
    output logic             usi_ack_rx_o,
    output logic             dmac_req_tx_o,
    output logic             dmac_req_rx_o,
    input  logic             dmac_ack_tx_i,
    input  logic             dmac_ack_rx_i,
    input  logic             dmac_sec_tx_i,
    input  logic             dmac_sec_rx_i,
    output logic [CNT_W-1:0] cnt_tx_o,
    output logic [CNT_W-1:0] cnt_rx_o,
    output logic [1:0]       err_to_o,
    output logic [1:0]       sec_viol_o,
    output logic             irq_o
);

    logic irq_q;

    usi_dma_hs_chan #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)) uChanTx (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .clr_i      (clr_i),
        .trust_i    (tipc_trust_i),
        .usi_req_i  (usi_req_tx_i),
        .dmac_ack_i (dmac_ack_tx_i),
        .dmac_sec_i (dmac_sec_tx_i),
        .usi_ack_o  (usi_ack_tx_o),
        .dmac_req_o (dmac_req_tx_o),
        .cnt_o      (cnt_tx_o),
        .err_to_o   (err_to_o[0]),
        .sec_viol_o (sec_viol_o[0])
    );

    usi_dma_hs_chan #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)) uChanRx (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .clr_i      (clr_i),
        .trust_i    (tipc_trust_i),
        .usi_req_i  (usi_req_rx_i),
        .dmac_ack_i (dmac_ack_rx_i),
        .dmac_sec_i (dmac_sec_rx_i),
        .usi_ack_o  (usi_ack_rx_o),
        .dmac_req_o (dmac_req_rx_o),
        .cnt_o      (cnt_rx_o),
        .err_to_o   (err_to_o[1]),
        .sec_viol_o (sec_viol_o[1])
    );

    // Interrupt is a registered OR of the sticky flags, so it trails them by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) irq_q <= 1'b0;
        else       irq_q <= |{err_to_o, sec_viol_o};
    end

    assign irq_o = irq_q;

endmodule
